// File: rtl/pipe_chain_ctrl_pkg.sv
// pipe_chain_ctrl_pkg
// Purpose: shared default parameters and the flattened-bus slicing helper
//          used by the pipe_chain_ctrl controller and its stage registers.
// Ports:   none (package).
package pipe_chain_ctrl_pkg;

   localparam int DEF_STAGES = 5;
   localparam int DEF_BUS_W  = 64;
   localparam int DEF_CNT_W  = 32;

   // Low bit index of lane k in a bus built from equal lanes of width w.
   function automatic int slice_lo(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/pipe_chain_ctrl_stage_reg.sv
// pipe_chain_ctrl_stage_reg
// Purpose: one pipeline stage register: a valid bit plus a BUS_W data latch.
// Ports:
//   clk, reset  clock / asynchronous active-high reset
//   allow       this stage may take a new item (or a bubble) this cycle
//   src_v       the upstream source offers an item
//   src_d       the offered item
//   kill        a flush from an older stage drops this stage's item
//   valid       stage holds a live item
//   data        latched item
module pipe_chain_ctrl_stage_reg #(
   parameter int BUS_W = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             allow,
   input  logic             src_v,
   input  logic [BUS_W-1:0] src_d,
   input  logic             kill,
   output logic             valid,
   output logic [BUS_W-1:0] data
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid <= 1'b0;
         data  <= '0;
      end else begin
         // Kill overrides the normal update; the data latch is free to move
         // because a dead stage's data is never looked at.
         if (kill)
            valid <= 1'b0;
         else if (allow)
            valid <= src_v;
         if (allow && src_v)
            data <= src_d;
      end
   end

endmodule

// File: rtl/pipe_chain_ctrl.sv
// pipe_chain_ctrl
// Purpose: N-stage valid/allow pipeline controller. Owns every stage valid
//          bit and latched bus, the backward allow chain, flush decode and
//          retire/stall counters.
// Ports:
//   clk, reset              clock / asynchronous active-high reset
//   in_valid, in_data       producer offer into stage 0
//   in_allow                stage 0 accepts this cycle
//   stage_over              per-stage "work finished" from stage logic
//   stage_bus               per-stage logic result (lane k = stage k)
//   flush_req               bit k kills stages 0..k-1
//   stage_valid, stage_data per-stage register contents
//   out_valid, out_data     last stage result offered to the consumer
//   out_ready               consumer accepts
//   retire_cnt, stall_cnt   out_valid&out_ready / out_valid&~out_ready cycles
//
// Handshake: a transfer across any boundary happens on a rising edge where
// the sender's valid and the receiver's allow (ready) are both high. Valid
// never depends on allow; allow depends on downstream allow (backward chain).
module pipe_chain_ctrl
   import pipe_chain_ctrl_pkg::*;
#(
   parameter int STAGES = DEF_STAGES,
   parameter int BUS_W  = DEF_BUS_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_allow,
   input  logic [BUS_W-1:0]        in_data,
   input  logic [STAGES-1:0]       stage_over,
   input  logic [STAGES*BUS_W-1:0] stage_bus,
   input  logic [STAGES-1:0]       flush_req,
   output logic [STAGES-1:0]       stage_valid,
   output logic [STAGES*BUS_W-1:0] stage_data,
   output logic                    out_valid,
   output logic [BUS_W-1:0]        out_data,
   input  logic                    out_ready,
   output logic [CNT_W-1:0]        retire_cnt,
   output logic [CNT_W-1:0]        stall_cnt
);

   logic [STAGES:0]         allow;
   logic [STAGES-1:0]       src_v;
   logic [STAGES*BUS_W-1:0] src_d;
   logic [STAGES-1:0]       kill;
   logic                    older_flush;

   // Backward allow chain: a stage can take something if it is empty, or
   // its item is done and the next stage can take it.
   always_comb begin
      allow         = '0;
      allow[STAGES] = out_ready;
      for (int k = STAGES - 1; k >= 0; k--)
         allow[k] = ~stage_valid[k] | (stage_over[k] & allow[k+1]);
   end

   assign in_allow = allow[0];

   // Forward sources: stage 0 from the producer, stage k from stage k-1 logic.
   always_comb begin
      src_v                 = '0;
      src_d                 = '0;
      src_v[0]              = in_valid;
      src_d[BUS_W-1:0]      = in_data;
      for (int k = 1; k < STAGES; k++) begin
         src_v[k] = stage_valid[k-1] & stage_over[k-1];
         src_d[slice_lo(k, BUS_W) +: BUS_W] = stage_bus[slice_lo(k-1, BUS_W) +: BUS_W];
      end
   end

   // Stage j dies when any flush bit above it is set; this makes the highest
   // requested bit win and turns flush_req[0] into a no-op.
   always_comb begin
      kill        = '0;
      older_flush = 1'b0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         kill[k]     = older_flush;
         older_flush = older_flush | flush_req[k];
      end
   end

   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      pipe_chain_ctrl_stage_reg #(
         .BUS_W (BUS_W)
      ) u_reg (
         .clk   (clk),
         .reset (reset),
         .allow (allow[g]),
         .src_v (src_v[g]),
         .src_d (src_d[g*BUS_W +: BUS_W]),
         .kill  (kill[g]),
         .valid (stage_valid[g]),
         .data  (stage_data[g*BUS_W +: BUS_W])
      );
   end

   assign out_valid = stage_valid[STAGES-1] & stage_over[STAGES-1];
   assign out_data  = stage_bus[slice_lo(STAGES-1, BUS_W) +: BUS_W];

   // Counters wrap naturally at 2^CNT_W.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         retire_cnt <= '0;
         stall_cnt  <= '0;
      end else if (out_valid) begin
         if (out_ready)
            retire_cnt <= retire_cnt + CNT_W'(1);
         else
            stall_cnt  <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_chain_ctrl.sv
// tb_pipe_chain_ctrl
// Purpose: self-checking bench for pipe_chain_ctrl (5 stages, 8-bit bus,
//          4-bit counters). Stage logic is a pass-through of the latched bus.
module tb_pipe_chain_ctrl;

   localparam int S = 5;
   localparam int W = 8;
   localparam int C = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic             in_valid;
   logic             in_allow;
   logic [W-1:0]     in_data;
   logic [S-1:0]     stage_over;
   logic [S*W-1:0]   stage_bus;
   logic [S-1:0]     flush_req;
   logic [S-1:0]     stage_valid;
   logic [S*W-1:0]   stage_data;
   logic             out_valid;
   logic [W-1:0]     out_data;
   logic             out_ready;
   logic [C-1:0]     retire_cnt;
   logic [C-1:0]     stall_cnt;

   assign stage_bus = stage_data;

   pipe_chain_ctrl #(
      .STAGES (S),
      .BUS_W  (W),
      .CNT_W  (C)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_allow    (in_allow),
      .in_data     (in_data),
      .stage_over  (stage_over),
      .stage_bus   (stage_bus),
      .flush_req   (flush_req),
      .stage_valid (stage_valid),
      .stage_data  (stage_data),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .retire_cnt  (retire_cnt),
      .stall_cnt   (stall_cnt)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- reference model ----------------
   // Slot occupancy of the pipe plus the in-order list of live items.
   logic [S-1:0] m_v;
   logic [W-1:0] m_d [S];
   logic [C-1:0] m_ret, m_stall;
   logic [W-1:0] exp_q[$];

   // Per-cycle results captured before the edge.
   logic         e_in_allow, e_out_valid, m_retire;
   logic [W-1:0] e_out_data, e_item;
   logic         s_in_allow, s_out_valid;
   logic [W-1:0] s_out_data;
   logic [W-1:0] nxt_in, nxt_out;

   task automatic model_clear();
      m_v     = '0;
      for (int k = 0; k < S; k++) m_d[k] = '0;
      m_ret   = '0;
      m_stall = '0;
      exp_q.delete();
   endtask

   // ---------------- driver ----------------
   // Applies one cycle of inputs, records the pre-edge outputs, advances the
   // model by one clock, and returns 1 time unit after the edge.
   task automatic drive_cycle(input logic iv, input logic [W-1:0] id, input logic [S-1:0] ov,
                              input logic ordy, input logic [S-1:0] fl);
      logic [S:0]   free_slot;
      logic [S-1:0] moves, nv;
      logic [W-1:0] nd [S];
      int           f, killed;
      in_valid   = iv;
      in_data    = id;
      stage_over = ov;
      out_ready  = ordy;
      flush_req  = fl;
      #1;
      // An item advances when done and the slot ahead empties this cycle;
      // the consumer acts as the slot after the last stage.
      free_slot[S] = ordy;
      for (int k = S - 1; k >= 0; k--) begin
         moves[k]     = m_v[k] & ov[k] & free_slot[k+1];
         free_slot[k] = ~m_v[k] | moves[k];
      end
      e_in_allow  = free_slot[0];
      e_out_valid = m_v[S-1] & ov[S-1];
      e_out_data  = m_d[S-1];
      m_retire    = e_out_valid & ordy;
      s_in_allow  = in_allow;
      s_out_valid = out_valid;
      s_out_data  = out_data;
      e_item      = 'x;
      if (m_retire && exp_q.size() > 0) e_item = exp_q.pop_front();
      for (int k = 0; k < S; k++) begin
         nv[k] = m_v[k] & ~moves[k];
         nd[k] = m_d[k];
      end
      for (int k = 1; k < S; k++)
         if (moves[k-1]) begin
            nv[k] = 1'b1;
            nd[k] = m_d[k-1];
         end
      f = 0;
      for (int k = 0; k < S; k++) if (fl[k]) f = k;
      killed = 0;
      for (int k = 0; k < S; k++)
         if (k < f) begin
            if (nv[k]) killed++;
            nv[k] = 1'b0;
         end
      repeat (killed) void'(exp_q.pop_back());
      if (iv && free_slot[0] && f == 0) begin
         nv[0] = 1'b1;
         nd[0] = id;
         exp_q.push_back(id);
      end
      if (e_out_valid) begin
         if (ordy) m_ret = m_ret + 1'b1;
         else      m_stall = m_stall + 1'b1;
      end
      @(posedge clk);
      m_v = nv;
      m_d = nd;
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      in_valid = 1'b0; in_data = '0; stage_over = '0;
      out_ready = 1'b0; flush_req = '0;
      @(negedge clk);
      n_checks++;
      if (stage_valid !== '0 || stage_data !== '0) begin
         n_fail++;
         $display("FAIL reset_regs: valid=%b data=%h expected 0/0", stage_valid, stage_data);
      end
      n_checks++;
      if (retire_cnt !== '0 || stall_cnt !== '0) begin
         n_fail++;
         $display("FAIL reset_cnt: retire=%0d stall=%0d expected 0/0", retire_cnt, stall_cnt);
      end
      n_checks++;
      if (out_valid !== 1'b0 || in_allow !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_hs: out_valid=%b in_allow=%b expected 0/1", out_valid, in_allow);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_clear();
   endtask

   task automatic test_stream();
      nxt_in  = 8'd1;
      nxt_out = 8'd1;
      for (int i = 0; i < 12; i++) begin
         drive_cycle(1'b1, nxt_in, '1, 1'b1, '0);
         if (s_in_allow) nxt_in = nxt_in + 1'b1;
         n_checks++;
         if (s_in_allow !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_allow: cycle %0d got %b expected 1", i, s_in_allow);
         end
         n_checks++;
         if (i < 5 && s_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_latency: cycle %0d out_valid=%b expected 0", i, s_out_valid);
         end else if (i >= 5 && (s_out_valid !== 1'b1 || s_out_data !== W'(i - 4))) begin
            n_fail++;
            $display("FAIL stream_out: cycle %0d got %b/%0d expected 1/%0d", i, s_out_valid, s_out_data, i - 4);
         end
         if (m_retire) nxt_out = nxt_out + 1'b1;
         n_checks++;
         if (retire_cnt !== C'(i >= 5 ? i - 4 : 0) || stall_cnt !== '0) begin
            n_fail++;
            $display("FAIL stream_cnt: cycle %0d retire=%0d stall=%0d expected %0d/0", i, retire_cnt, stall_cnt, i >= 5 ? i - 4 : 0);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [S*W-1:0] snap;
      logic [C-1:0]   stall0;
      snap   = stage_data;
      stall0 = stall_cnt;
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b1, nxt_in, '1, 1'b0, '0);
         if (s_in_allow) nxt_in = nxt_in + 1'b1;
         n_checks++;
         if (s_in_allow !== 1'b0 || s_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold: cycle %0d in_allow=%b out_valid=%b expected 0/1", i, s_in_allow, s_out_valid);
         end
         n_checks++;
         if (stage_data !== snap || stage_valid !== '1) begin
            n_fail++;
            $display("FAIL bp_frozen: cycle %0d data=%h valid=%b expected %h/11111", i, stage_data, stage_valid, snap);
         end
      end
      n_checks++;
      if (stall_cnt !== stall0 + C'(3)) begin
         n_fail++;
         $display("FAIL bp_stall_cnt: got %0d expected %0d", stall_cnt, stall0 + C'(3));
      end
      for (int i = 0; i < 8; i++) begin
         drive_cycle(1'b1, nxt_in, '1, 1'b1, '0);
         if (s_in_allow) nxt_in = nxt_in + 1'b1;
         if (m_retire) begin
            n_checks++;
            if (s_out_data !== nxt_out || s_out_data !== e_item) begin
               n_fail++;
               $display("FAIL bp_order: got %0d expected %0d", s_out_data, nxt_out);
            end
            nxt_out = nxt_out + 1'b1;
         end
      end
   endtask

   task automatic test_multicycle();
      logic [2*W-1:0] snap;
      snap = stage_data[2*W-1:0];
      for (int i = 0; i < 4; i++) begin
         drive_cycle(1'b1, nxt_in, 5'b11011, 1'b1, '0);
         if (s_in_allow) nxt_in = nxt_in + 1'b1;
         if (m_retire) nxt_out = nxt_out + 1'b1;
         n_checks++;
         if (stage_valid[3] !== 1'b0 || s_in_allow !== 1'b0) begin
            n_fail++;
            $display("FAIL mc_bubble: cycle %0d valid3=%b in_allow=%b expected 0/0", i, stage_valid[3], s_in_allow);
         end
         n_checks++;
         if (stage_data[2*W-1:0] !== snap) begin
            n_fail++;
            $display("FAIL mc_hold: cycle %0d stages0..1=%h expected %h", i, stage_data[2*W-1:0], snap);
         end
      end
      for (int i = 0; i < 10; i++) begin
         drive_cycle(1'b1, nxt_in, '1, 1'b1, '0);
         if (s_in_allow) nxt_in = nxt_in + 1'b1;
         if (m_retire) begin
            n_checks++;
            if (s_out_data !== nxt_out || s_out_data !== e_item) begin
               n_fail++;
               $display("FAIL mc_order: got %0d expected %0d", s_out_data, nxt_out);
            end
            nxt_out = nxt_out + 1'b1;
         end
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 6; i++) drive_cycle(1'b0, '0, '1, 1'b1, '0);
      for (int i = 0; i < 5; i++) drive_cycle(1'b1, W'(10 + i), '1, 1'b0, '0);
      n_checks++;
      if (stage_valid !== 5'b11111 || stage_data !== {8'd10, 8'd11, 8'd12, 8'd13, 8'd14}) begin
         n_fail++;
         $display("FAIL flush_fill: valid=%b data=%h expected 11111/0a0b0c0d0e", stage_valid, stage_data);
      end
      drive_cycle(1'b1, 8'd99, '1, 1'b1, 5'b10000);
      n_checks++;
      if (s_in_allow !== 1'b1 || s_out_valid !== 1'b1 || s_out_data !== 8'd10) begin
         n_fail++;
         $display("FAIL flush_retire: in_allow=%b out=%b/%0d expected 1/1/10", s_in_allow, s_out_valid, s_out_data);
      end
      n_checks++;
      if (stage_valid !== 5'b10000 || stage_data[4*W +: W] !== 8'd11) begin
         n_fail++;
         $display("FAIL flush_kill: valid=%b last=%0d expected 10000/11", stage_valid, stage_data[4*W +: W]);
      end
      drive_cycle(1'b0, '0, '1, 1'b1, '0);
      n_checks++;
      if (s_out_data !== 8'd11 || s_out_data !== e_item || stage_valid !== '0) begin
         n_fail++;
         $display("FAIL flush_drain: out=%0d valid=%b expected 11/00000", s_out_data, stage_valid);
      end
      for (int i = 0; i < 5; i++) drive_cycle(1'b1, W'(20 + i), '1, 1'b0, '0);
      drive_cycle(1'b1, 8'd99, '1, 1'b0, 5'b01001);
      n_checks++;
      if (stage_valid !== 5'b11000 || stage_valid !== m_v) begin
         n_fail++;
         $display("FAIL flush_multi: valid=%b expected 11000", stage_valid);
      end
      for (int i = 0; i < 2; i++) begin
         drive_cycle(1'b0, '0, '1, 1'b1, '0);
         n_checks++;
         if (s_out_valid !== 1'b1 || s_out_data !== W'(20 + i) || s_out_data !== e_item) begin
            n_fail++;
            $display("FAIL flush_multi_out: got %b/%0d expected 1/%0d", s_out_valid, s_out_data, 20 + i);
         end
      end
      n_checks++;
      if (stage_valid !== '0) begin
         n_fail++;
         $display("FAIL flush_multi_empty: valid=%b expected 00000", stage_valid);
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 7; i++) drive_cycle(1'b1, W'(40 + i), '1, 1'b1, '0);
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if (stage_valid !== '0 || retire_cnt !== '0 || stall_cnt !== '0) begin
         n_fail++;
         $display("FAIL areset_clear: valid=%b retire=%0d stall=%0d expected 0/0/0", stage_valid, retire_cnt, stall_cnt);
      end
      n_checks++;
      if (out_valid !== 1'b0 || in_allow !== 1'b1) begin
         n_fail++;
         $display("FAIL areset_hs: out_valid=%b in_allow=%b expected 0/1", out_valid, in_allow);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_clear();
      for (int i = 0; i < 9; i++) begin
         drive_cycle(1'b1, W'(60 + i), '1, 1'b1, '0);
         if (i >= 5) begin
            n_checks++;
            if (s_out_valid !== 1'b1 || s_out_data !== W'(55 + i)) begin
               n_fail++;
               $display("FAIL areset_resume: cycle %0d got %b/%0d expected 1/%0d", i, s_out_valid, s_out_data, 55 + i);
            end
         end
      end
   endtask

   task automatic test_counter_wrap();
      reset = 1'b1;
      #1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_clear();
      for (int i = 0; i < 22; i++) drive_cycle(1'b1, W'(i), '1, 1'b1, '0);
      n_checks++;
      if (retire_cnt !== 4'd1 || retire_cnt !== m_ret) begin
         n_fail++;
         $display("FAIL cnt_wrap: retire=%0d expected 1", retire_cnt);
      end
   endtask

   task automatic test_random();
      logic         iv, ordy;
      logic [S-1:0] ov, fl;
      for (int i = 0; i < 400; i++) begin
         iv   = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 9) < 7);
         for (int k = 0; k < S; k++) ov[k] = ($urandom_range(0, 3) != 0);
         fl   = ($urandom_range(0, 11) == 0) ? S'($urandom_range(0, 31)) : '0;
         drive_cycle(iv, W'($urandom_range(0, 255)), ov, ordy, fl);
         n_checks++;
         if (s_in_allow !== e_in_allow || s_out_valid !== e_out_valid) begin
            n_fail++;
            $display("FAIL rnd_hs: cycle %0d allow/out_valid=%b/%b expected %b/%b", i, s_in_allow, s_out_valid, e_in_allow, e_out_valid);
         end
         if (e_out_valid) begin
            n_checks++;
            if (s_out_data !== e_out_data) begin
               n_fail++;
               $display("FAIL rnd_out: cycle %0d got %0d expected %0d", i, s_out_data, e_out_data);
            end
         end
         if (m_retire) begin
            n_checks++;
            if (s_out_data !== e_item) begin
               n_fail++;
               $display("FAIL rnd_order: cycle %0d got %0d expected %0d", i, s_out_data, e_item);
            end
         end
         n_checks++;
         if (stage_valid !== m_v) begin
            n_fail++;
            $display("FAIL rnd_valid: cycle %0d got %b expected %b", i, stage_valid, m_v);
         end
         for (int k = 0; k < S; k++)
            if (m_v[k]) begin
               n_checks++;
               if (stage_data[k*W +: W] !== m_d[k]) begin
                  n_fail++;
                  $display("FAIL rnd_data: cycle %0d stage %0d got %0d expected %0d", i, k, stage_data[k*W +: W], m_d[k]);
               end
            end
         n_checks++;
         if (retire_cnt !== m_ret || stall_cnt !== m_stall) begin
            n_fail++;
            $display("FAIL rnd_cnt: cycle %0d retire/stall=%0d/%0d expected %0d/%0d", i, retire_cnt, stall_cnt, m_ret, m_stall);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_multicycle();
      test_flush();
      test_async_reset();
      test_counter_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
